// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared types and default dimensions for the pixel reassembly path.
//   coord_t      : pixel coordinate as carried by the engine reorder queues
//   colour_t     : packed RGB colour
//   comb_state_t : frame assembly state of pixel_combinator
// No ports (package).
// -----------------------------------------------------------------------------
package pixel_pkg;

    localparam int NUM_ENGINES    = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int RBG_SIZE       = 24;
    localparam int X_SIZE         = 640;
    localparam int Y_SIZE         = 480;
    localparam int TIMEOUT_CYCLES = 4096;

    typedef logic [DATA_WIDTH-1:0] coord_t;
    typedef logic [RBG_SIZE-1:0]   colour_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } comb_state_t;

endpackage

// File: rtl/first_match_sel.sv
// -----------------------------------------------------------------------------
// first_match_sel
// Fixed-priority selector: grants the lowest-index set bit of match.
// Ports:
//   match [N-1:0] in  : per-queue match flags
//   grant [N-1:0] out : one-hot grant of the lowest set match bit (0 if none)
//   any           out : at least one match bit is set
// Purely combinational.
// -----------------------------------------------------------------------------
module first_match_sel
    import pixel_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] match,
    output logic [N-1:0] grant,
    output logic         any
);

    logic found;

    // Walk from index 0 upwards; once a match is found, mask all higher bits.
    always_comb begin
        grant = {N{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            grant[i] = match[i] & ~found;
            found    = found | match[i];
        end
    end

    assign any = |match;

endmodule

// File: rtl/pixel_combinator.sv
// -----------------------------------------------------------------------------
// pixel_combinator
// Rebuilds the raster-order pixel stream from NUM_ENGINES reorder queues. The
// next expected (x,y) is compared with every queue head; the lowest-index
// matching queue is popped and its colour registered onto a ready/valid video
// output together with start-of-frame / end-of-line flags.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   run               : level, permits frame assembly (sampled at frame end)
//   head_valid/x/y/colour : packed queue head entries, slice i = queue i
//   pop               : one-hot, combinational; queue i drops its head this edge
//   xpixel_check/ypixel_check : current expected coordinate
//   out_valid/out_ready/out_colour/out_sof/out_eol : video output stream
//   frame_done        : one-cycle pulse alongside the last pixel of a frame
//   stall_err         : sticky, no matching head for TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
module pixel_combinator #(
    parameter int NUM_ENGINES    = pixel_pkg::NUM_ENGINES,
    parameter int DATA_WIDTH     = pixel_pkg::DATA_WIDTH,
    parameter int RBG_SIZE       = pixel_pkg::RBG_SIZE,
    parameter int X_SIZE         = pixel_pkg::X_SIZE,
    parameter int Y_SIZE         = pixel_pkg::Y_SIZE,
    parameter int TIMEOUT_CYCLES = pixel_pkg::TIMEOUT_CYCLES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run,
    input  logic [NUM_ENGINES-1:0]          head_valid,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0] head_x,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0] head_y,
    input  logic [NUM_ENGINES*RBG_SIZE-1:0]   head_colour,
    output logic [NUM_ENGINES-1:0]          pop,
    output logic [DATA_WIDTH-1:0]           xpixel_check,
    output logic [DATA_WIDTH-1:0]           ypixel_check,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [RBG_SIZE-1:0]             out_colour,
    output logic                            out_sof,
    output logic                            out_eol,
    output logic                            frame_done,
    output logic                            stall_err
);

    import pixel_pkg::*;

    localparam int                    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      STALL_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] X_LAST    = DATA_WIDTH'(X_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST    = DATA_WIDTH'(Y_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] COORD_0   = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] COORD_1   = DATA_WIDTH'(1);

    comb_state_t             state_q,      state_d;
    logic [DATA_WIDTH-1:0]   x_exp_q,      x_exp_d;
    logic [DATA_WIDTH-1:0]   y_exp_q,      y_exp_d;
    logic                    out_valid_q,  out_valid_d;
    logic [RBG_SIZE-1:0]     out_colour_q, out_colour_d;
    logic                    out_sof_q,    out_sof_d;
    logic                    out_eol_q,    out_eol_d;
    logic                    frame_done_q, frame_done_d;
    logic                    stall_err_q,  stall_err_d;
    logic [CNT_W-1:0]        stall_cnt_q,  stall_cnt_d;

    logic [NUM_ENGINES-1:0]  match;
    logic [NUM_ENGINES-1:0]  grant;
    logic                    any_match;
    logic [RBG_SIZE-1:0]     sel_colour;
    logic                    can_load;
    logic                    fire;
    logic                    at_line_end;
    logic                    at_frame_end;

    // Compare every queue head against the expected coordinate (full width).
    always_comb begin
        match = {NUM_ENGINES{1'b0}};
        for (int i = 0; i < NUM_ENGINES; i++) begin
            match[i] = head_valid[i]
                     && (head_x[i*DATA_WIDTH +: DATA_WIDTH] == x_exp_q)
                     && (head_y[i*DATA_WIDTH +: DATA_WIDTH] == y_exp_q);
        end
    end

    first_match_sel #(
        .N (NUM_ENGINES)
    ) u_first_match_sel (
        .match (match),
        .grant (grant),
        .any   (any_match)
    );

    // AND-OR colour mux driven by the one-hot grant.
    always_comb begin
        sel_colour = {RBG_SIZE{1'b0}};
        for (int i = 0; i < NUM_ENGINES; i++) begin
            sel_colour = sel_colour
                       | (head_colour[i*RBG_SIZE +: RBG_SIZE] & {RBG_SIZE{grant[i]}});
        end
    end

    assign can_load     = !out_valid_q || out_ready;
    assign at_line_end  = (x_exp_q == X_LAST);
    assign at_frame_end = at_line_end && (y_exp_q == Y_LAST);
    // Gating with reset keeps pop low while the queues are being reset.
    assign fire         = !reset && (state_q == RUN) && any_match && can_load;
    assign pop          = fire ? grant : {NUM_ENGINES{1'b0}};

    // Next-state: FSM, raster counters, output stage and stall watchdog.
    always_comb begin
        state_d      = state_q;
        x_exp_d      = x_exp_q;
        y_exp_d      = y_exp_q;
        out_valid_d  = out_valid_q;
        out_colour_d = out_colour_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        frame_done_d = fire && at_frame_end;
        stall_cnt_d  = stall_cnt_q;

        // run is only looked at between frames, so a frame always completes.
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (fire && at_frame_end && !run) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fire) begin
            out_valid_d  = 1'b1;
            out_colour_d = sel_colour;
            out_sof_d    = (x_exp_q == COORD_0) && (y_exp_q == COORD_0);
            out_eol_d    = at_line_end;
            if (at_frame_end) begin
                x_exp_d = COORD_0;
                y_exp_d = COORD_0;
            end else if (at_line_end) begin
                x_exp_d = COORD_0;
                y_exp_d = y_exp_q + COORD_1;
            end else begin
                x_exp_d = x_exp_q + COORD_1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // Only genuine starvation counts: a blocked output is not a stall.
        if (fire) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if ((state_q == RUN) && can_load && !any_match
                     && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        stall_err_d = stall_err_q || (stall_cnt_d == STALL_MAX);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_exp_q      <= COORD_0;
            y_exp_q      <= COORD_0;
            out_valid_q  <= 1'b0;
            out_colour_q <= {RBG_SIZE{1'b0}};
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            stall_err_q  <= 1'b0;
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            x_exp_q      <= x_exp_d;
            y_exp_q      <= y_exp_d;
            out_valid_q  <= out_valid_d;
            out_colour_q <= out_colour_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            frame_done_q <= frame_done_d;
            stall_err_q  <= stall_err_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign xpixel_check = x_exp_q;
    assign ypixel_check = y_exp_q;
    assign out_valid    = out_valid_q;
    assign out_colour   = out_colour_q;
    assign out_sof      = out_sof_q;
    assign out_eol      = out_eol_q;
    assign frame_done   = frame_done_q;
    assign stall_err    = stall_err_q;

endmodule

// File: tb/tb_pixel_combinator.sv
// -----------------------------------------------------------------------------
// tb_pixel_combinator
// Small-frame (4x2) bench for pixel_combinator. Models the engine queues as
// SV queues, pushes expected output pixels onto a scoreboard as they are
// loaded, and compares each pixel accepted by the output handshake.
// -----------------------------------------------------------------------------
module tb_pixel_combinator;

    localparam int NE = 4;
    localparam int DW = 32;
    localparam int CW = 24;
    localparam int XS = 4;
    localparam int YS = 2;
    localparam int TO = 16;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [CW-1:0] c;
    } ent_t;

    typedef struct {
        logic [CW-1:0] c;
        logic          sof;
        logic          eol;
        logic          last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 run;
    logic [NE-1:0]        head_valid;
    logic [NE*DW-1:0]     head_x;
    logic [NE*DW-1:0]     head_y;
    logic [NE*CW-1:0]     head_colour;
    logic [NE-1:0]        pop;
    logic [DW-1:0]        xpixel_check;
    logic [DW-1:0]        ypixel_check;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        out_colour;
    logic                 out_sof;
    logic                 out_eol;
    logic                 frame_done;
    logic                 stall_err;

    ent_t          qs[NE][$];
    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            fd_count = 0;
    logic [NE-1:0] last_pop;

    pixel_combinator #(
        .NUM_ENGINES    (NE),
        .DATA_WIDTH     (DW),
        .RBG_SIZE       (CW),
        .X_SIZE         (XS),
        .Y_SIZE         (YS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .head_valid   (head_valid),
        .head_x       (head_x),
        .head_y       (head_y),
        .head_colour  (head_colour),
        .pop          (pop),
        .xpixel_check (xpixel_check),
        .ypixel_check (ypixel_check),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_colour   (out_colour),
        .out_sof      (out_sof),
        .out_eol      (out_eol),
        .frame_done   (frame_done),
        .stall_err    (stall_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NE; i++) begin
            if (qs[i].size() > 0) begin
                head_valid[i]              = 1'b1;
                head_x[i*DW +: DW]         = qs[i][0].x;
                head_y[i*DW +: DW]         = qs[i][0].y;
                head_colour[i*CW +: CW]    = qs[i][0].c;
            end else begin
                head_valid[i]              = 1'b0;
                head_x[i*DW +: DW]         = '0;
                head_y[i*DW +: DW]         = '0;
                head_colour[i*CW +: CW]    = '0;
            end
        end
    endtask

    // Put an entry into queue q; if it will be output, push its expectation.
    task automatic load(input int q, input int x, input int y,
                        input logic [CW-1:0] c, input bit expect_out);
        ent_t e;
        exp_t x_e;
        e.x = DW'(x);
        e.y = DW'(y);
        e.c = c;
        qs[q].push_back(e);
        if (expect_out) begin
            x_e.c    = c;
            x_e.sof  = (x == 0) && (y == 0);
            x_e.eol  = (x == XS - 1);
            x_e.last = (x == XS - 1) && (y == YS - 1);
            sb.push_back(x_e);
        end
        drive_heads();
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NE; i++) qs[i].delete();
        sb.delete();
        drive_heads();
    endtask

    // One clock: sample/compare at negedge, retire popped heads after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_pop = pop;
        if (!reset) begin
            if (frame_done) fd_count++;
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_colour", 64'(out_colour), 64'(e.c));
                    check("out_sof", 64'(out_sof), 64'(e.sof));
                    check("out_eol", 64'(out_eol), 64'(e.eol));
                    check("frame_done", 64'(frame_done), 64'(e.last));
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NE; i++) begin
            if (last_pop[i] && (qs[i].size() > 0)) void'(qs[i].pop_front());
        end
        drive_heads();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        out_ready   = 1'b1;
        head_valid  = '0;
        head_x      = '0;
        head_y      = '0;
        head_colour = '0;
        last_pop    = '0;
        drive_heads();

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_pop", 64'(pop), 64'd0);
        check("rst_x", 64'(xpixel_check), 64'd0);
        check("rst_y", 64'(ypixel_check), 64'd0);
        check("rst_colour", 64'(out_colour), 64'd0);
        check("rst_sof", 64'(out_sof), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_stall_err", 64'(stall_err), 64'd0);
        reset = 1'b0;

        // First pixel from queue 0
        load(0, 0, 0, 24'hFF0000, 1'b1);
        run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_pop != '0) break;
        end
        check("a_pop", 64'(last_pop), 64'd1);
        check("a_out_valid", 64'(out_valid), 64'd1);
        check("a_out_colour", 64'(out_colour), 64'hFF0000);
        check("a_out_sof", 64'(out_sof), 64'd1);
        check("a_x_exp", 64'(xpixel_check), 64'd1);

        // Rest of the 4x2 frame, round-robin across the queues
        for (int k = 1; k < XS * YS; k++) begin
            load(k % NE, k % XS, k / XS, 24'h00A000 + CW'(k), 1'b1);
        end
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("b_drained", 64'(sb.size()), 64'd0);
        tick();
        tick();
        tick();
        check("b_frame_done_pulses", 64'(fd_count), 64'd1);
        check("b_x_wrap", 64'(xpixel_check), 64'd0);
        check("b_y_wrap", 64'(ypixel_check), 64'd0);

        // Two queues match (0,0): only the lower index is popped
        load(1, 0, 0, 24'hAA0001, 1'b1);
        load(2, 0, 0, 24'hBB0002, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (last_pop != '0) break;
        end
        check("c_pop_lowest", 64'(last_pop), 64'b0010);

        // Backpressure with a matching head present
        out_ready = 1'b0;
        load(3, 1, 0, 24'hDD0001, 1'b1);
        load(3, 2, 0, 24'hDD0002, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("d_pop_blocked", 64'(last_pop), 64'd0);
            check("d_valid_held", 64'(out_valid), 64'd1);
            check("d_colour_held", 64'(out_colour), 64'hAA0001);
            check("d_x_held", 64'(xpixel_check), 64'd1);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("d_drained", 64'(sb.size()), 64'd0);
        check("c_q2_retained", 64'(qs[2].size()), 64'd1);
        check("d_x_after", 64'(xpixel_check), 64'd3);

        // Reset in the middle of a frame at pixel (2,1)
        load(0, 3, 0, 24'hEE0000, 1'b1);
        load(1, 0, 1, 24'hEE0001, 1'b1);
        load(1, 1, 1, 24'hEE0002, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            if ((xpixel_check == DW'(2)) && (ypixel_check == DW'(1))) break;
        end
        check("f_at_x2", 64'(xpixel_check), 64'd2);
        check("f_at_y1", 64'(ypixel_check), 64'd1);
        reset = 1'b1;
        tick();
        check("f_rst_out_valid", 64'(out_valid), 64'd0);
        check("f_rst_pop", 64'(pop), 64'd0);
        check("f_rst_x", 64'(xpixel_check), 64'd0);
        check("f_rst_y", 64'(ypixel_check), 64'd0);
        clear_queues();
        run   = 1'b0;
        reset = 1'b0;
        load(0, 0, 0, 24'h112233, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("f_idle_no_pop", 64'(last_pop), 64'd0);
            check("f_idle_no_valid", 64'(out_valid), 64'd0);
        end

        // Stall watchdog with no matching head
        clear_queues();
        load(1, 3, 1, 24'h445566, 1'b0);
        run = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("e_stall_early", 64'(stall_err), 64'd0);
        for (int k = 0; k < 20; k++) tick();
        check("e_stall_set", 64'(stall_err), 64'd1);
        for (int k = 0; k < 5; k++) tick();
        check("e_stall_sticky", 64'(stall_err), 64'd1);
        check("e_stall_no_pop", 64'(last_pop), 64'd0);
        reset = 1'b1;
        tick();
        tick();
        check("e_stall_cleared", 64'(stall_err), 64'd0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_combinator.md
Name: pixel_combinator

Overview:
- Reassembles the raster-order pixel stream from the NUM_ENGINES per-engine reorder queues.
- Holds the next expected (x,y) coordinate and compares it against every queue head. Pops the matching queue and registers the colour into a ready/valid video output with start-of-frame and end-of-line flags.
- Sits directly downstream of the per-engine queues and upstream of the video output/VGA stage.

Parameters:
- NUM_ENGINES, 4, number of engine queues feeding this block
- DATA_WIDTH, 32, coordinate width (matches queue x/y width)
- RBG_SIZE, 24, colour width
- X_SIZE, 640, pixels per line
- Y_SIZE, 480, lines per frame
- TIMEOUT_CYCLES, 4096, stall cycles before stall_err is set

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; permits frame assembly
- head_valid  in  NUM_ENGINES  queue i head entry valid (non-empty)
- head_x  in  NUM_ENGINES*DATA_WIDTH  packed head x per queue, slice i = queue i
- head_y  in  NUM_ENGINES*DATA_WIDTH  packed head y per queue
- head_colour  in  NUM_ENGINES*RBG_SIZE  packed head colour per queue
- pop  out  NUM_ENGINES  one-hot, combinational; queue i removes its head at this clk edge
- xpixel_check  out  DATA_WIDTH  current expected x (x_exp)
- ypixel_check  out  DATA_WIDTH  current expected y (y_exp)
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_colour  out  RBG_SIZE  pixel colour
- out_sof  out  1  pixel is (0,0)
- out_eol  out  1  pixel is x = X_SIZE-1
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is loaded
- stall_err  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE, x_exp=0, y_exp=0, out_valid=0, out_colour=0, out_sof=0, out_eol=0, frame_done=0, stall_err=0, stall_cnt=0. pop=0 while reset is high.
- FSM IDLE: pop=0. Go to RUN when run=1.
- FSM RUN: assemble the frame.
  - At the last-pixel fire, go to IDLE if run=0, else stay in RUN for the next frame.
  - Deasserting run mid-frame takes effect only at frame end.
- match[i] = head_valid[i] && head_x[i]==x_exp && head_y[i]==y_exp. Full DATA_WIDTH unsigned compare.
- sel = lowest index with match set. Other matching queues are not popped.
- can_load = !out_valid || out_ready.
- fire = (state==RUN) && |match && can_load.
  - pop = onehot(sel) when fire, else 0.
- On fire:
  - out_colour<=head_colour[sel], out_valid<=1.
  - out_sof<=(x_exp==0 && y_exp==0), out_eol<=(x_exp==X_SIZE-1).
  - Advance x_exp by 1. At X_SIZE-1, x_exp<=0 and y_exp advances by 1.
  - At (X_SIZE-1, Y_SIZE-1), both wrap to 0 and frame_done<=1 on the next cycle only.
- No fire and out_ready: out_valid<=0. No fire and !out_ready: hold all output registers.
- Latency: match at cycle t -> out_valid at t+1.
- Throughput: 1 pixel/cycle while matches are present and out_ready=1.
- Backpressure: out_valid && !out_ready blocks fire. pop=0 and x_exp/y_exp hold.
- stall_cnt:
  - Increments in RUN when can_load && !|match; clears on fire.
  - Saturates at TIMEOUT_CYCLES, where stall_err<=1 (sticky until reset).
  - stall_err has no effect on the datapath.
- Reset mid-frame: everything returns to reset values on the next edge. The queues are reset by the same signal.
- xpixel_check/ypixel_check are registered copies of x_exp/y_exp (no extra delay).

Decomposition:
- Shared package pixel_pkg:
  - coord_t (logic [DATA_WIDTH-1:0]), colour_t (logic [RBG_SIZE-1:0])
  - X_SIZE, Y_SIZE, NUM_ENGINES constants
  - combinator state enum {IDLE, RUN}
- One sub-module: first_match_sel (parameterised priority encoder, NUM_ENGINES-bit match -> one-hot grant + any flag).

Test Plan:
- Reset, run=1, queue0 head (0,0,0xFF0000) valid, out_ready=1 -> pop=0001 that cycle. Next cycle out_valid=1, out_colour=0xFF0000, out_sof=1, x_exp=1.
- X_SIZE=4, Y_SIZE=2, 4 queues each holding round-robin pixels, out_ready=1 -> 8 consecutive outputs in raster order, out_eol at x=3. frame_done pulses once, one cycle after the 8th output is loaded.
- Queues 1 and 2 both present (0,0) -> pop=0010 only; queue 2 retains its head.
- out_ready=0 for 5 cycles with matching head present -> out_valid held, out_colour stable, pop=0, x_exp unchanged. Resumes on out_ready=1.
- TIMEOUT_CYCLES=16, run=1, no head matches -> stall_err=1 after 16 cycles, stays 1. Cleared only by reset.
- Reset asserted at pixel (2,1) -> next cycle out_valid=0, pop=0, xpixel_check=0, ypixel_check=0, state IDLE.
